// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package whack_pkg;

  typedef enum logic [2:0] {IDLE, SPAWN, WAIT, GAP, DONE} game_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/whack_lfsr.sv
// Free-running Fibonacci LFSR; shifts left every cycle, feedback enters at bit 0.
module whack_lfsr
  import whack_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] lfsr
);

  logic fb;

  assign fb = ^(lfsr & WIDTH'(LFSR_TAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: LFSR mole pick, per-mole timeout, hit/miss scoring, wrong-press lockout.
// Optional WHACK_WRONG_PENALTY_EN: each cycle with a wrong press costs one point (floor 0).
module whack_game_core
  import whack_pkg::*;
#(
  parameter int          N_MOLES     = 8,
  parameter int          SCORE_W     = 8,
  parameter int          TIMEOUT_CYC = 50000,
  parameter int          GAP_CYC     = 1000,
  parameter int          ROUNDS      = 20,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED,
  localparam int         IDX_W       = $clog2(N_MOLES),
  localparam int         RND_W       = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] mole_onehot,
  output logic [IDX_W-1:0]   mole_idx,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [N_MOLES-1:0] lockout,
  output logic [RND_W-1:0]   round_cnt,
  output logic               busy,
  output logic               game_over
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W:0] N_EXT  = (IDX_W + 1)'(N_MOLES);
  localparam logic [IDX_W:0] N_LAST = (IDX_W + 1)'(N_MOLES - 1);

  game_state_t        state, state_next;
  logic [15:0]        lfsr;
  logic [N_MOLES-1:0] btn_q, press, mole_sel;
  logic [IDX_W-1:0]   prev_idx, sel_idx;
  logic [IDX_W:0]     r_fold;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic               hit, miss, wrong, clr_game, do_spawn, gap_last;
  logic               unused_lfsr_hi;

  whack_lfsr #(
    .WIDTH (16),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:IDX_W];

  assign press       = btn & ~btn_q & ~lockout;
  assign mole_sel    = N_MOLES'(1) << mole_idx;
  assign mole_onehot = (state == WAIT) ? mole_sel : '0;
  assign busy        = (state == SPAWN) || (state == WAIT) || (state == GAP);
  assign game_over   = (state == DONE);
  assign gap_last    = (gap_cnt == GAP_W'(GAP_CYC - 1));

  // Fold the raw LFSR slice into range, then step past the previous mole
  always_comb begin
    r_fold = {1'b0, lfsr[IDX_W-1:0]};
    if (r_fold >= N_EXT) r_fold = r_fold - N_EXT;
    sel_idx = r_fold[IDX_W-1:0];
    if (sel_idx == prev_idx) begin
      sel_idx = (r_fold == N_LAST) ? '0 : sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hit        = 1'b0;
    miss       = 1'b0;
    wrong      = 1'b0;
    clr_game   = 1'b0;
    do_spawn   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clr_game   = 1'b1;
          state_next = SPAWN;
        end
      end
      SPAWN: begin
        do_spawn   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (|(press & mole_sel)) begin
          hit        = 1'b1;
          state_next = GAP;
        end else if (timer == '0) begin
          miss       = 1'b1;
          state_next = GAP;
        end else if (|press) begin
          wrong = 1'b1;
        end
      end
      GAP: begin
        if (gap_last) state_next = (round_cnt == RND_W'(ROUNDS)) ? DONE : SPAWN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= '0;
      mole_idx  <= '0;
      prev_idx  <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      score     <= '0;
      misses    <= '0;
      round_cnt <= '0;
      lockout   <= '0;
    end else begin
      btn_q <= btn;
      if (clr_game) begin
        score     <= '0;
        misses    <= '0;
        round_cnt <= '0;
        lockout   <= '0;
      end
      if (do_spawn) begin
        mole_idx <= sel_idx;
        prev_idx <= sel_idx;
        lockout  <= '0;
        timer    <= TMR_W'(TIMEOUT_CYC - 1);
      end else if ((state == WAIT) && (timer != '0)) begin
        timer <= timer - TMR_W'(1);
      end
      if (hit) begin
        if (score != '1) score <= score + SCORE_W'(1);
        round_cnt <= round_cnt + RND_W'(1);
      end
      if (miss) begin
        if (misses != '1) misses <= misses + SCORE_W'(1);
        round_cnt <= round_cnt + RND_W'(1);
      end
      if (wrong) begin
        lockout <= lockout | press;
`ifdef WHACK_WRONG_PENALTY_EN
        if (score != '0) score <= score - SCORE_W'(1);
`endif
      end
      if ((state == GAP) && !gap_last) gap_cnt <= gap_cnt + GAP_W'(1);
      else                             gap_cnt <= '0;
    end
  end

endmodule
